// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } md_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Magnitude restoring divider: one quotient bit per step, WIDTH steps per divide.
module muldiv_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        if (load_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (step_i) begin
            // Top bit of diff is the borrow: set means the trial subtract failed.
            if (diff[WIDTH]) begin
                rem_d  = shifted[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d  = diff[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit with start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned MaxCnt = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    md_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 dbz_q, dbz_d;
    logic                 qsign_q, qsign_d, rsign_q, rsign_d;

    logic                 op_signed;
    logic [2*WIDTH-1:0]   ext_a, ext_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic                 div_load, div_step;
    logic [WIDTH-1:0]     div_quot, div_rem;

    // MULT and DIV (op[0]==0) are the signed variants.
    assign op_signed = ~op_i[0];
    assign ext_a = {{WIDTH{op_signed & a_i[WIDTH-1]}}, a_i};
    assign ext_b = {{WIDTH{op_signed & b_i[WIDTH-1]}}, b_i};
    assign abs_a = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign abs_b = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        div_load = 1'b0;
        div_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !cancel_i) begin
                    if (!op_i[1]) begin
                        state_d = StMul;
                        cnt_d   = CntW'(MUL_LAT - 1);
                        prod_d  = ext_a * ext_b;
                    end else if (b_i == '0) begin
                        state_d = StDone;
                        lo_d    = '1;
                        hi_d    = a_i;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d  = StDiv;
                        cnt_d    = CntW'(WIDTH - 1);
                        div_load = 1'b1;
                        qsign_d  = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rsign_d  = op_signed & a_i[WIDTH-1];
                    end
                end
            end
            StMul: begin
                if (cnt_q == '0) begin
                    state_d      = StDone;
                    {hi_d, lo_d} = prod_q;
                    dbz_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                div_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                state_d = StDone;
                lo_d    = qsign_q ? -div_quot : div_quot;
                hi_d    = rsign_q ? -div_rem : div_rem;
                dbz_d   = 1'b0;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush abandons the operation without touching the architectural results.
        if (cancel_i && state_q != StIdle) begin
            state_d  = StIdle;
            hi_d     = hi_q;
            lo_d     = lo_q;
            dbz_d    = dbz_q;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end

    muldiv_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    assign busy_o        = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    assign done_o        = (state_q == StDone);
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule
